t_bird_panel_conditioner: RTL and testbench

Input conditioning stage between the raw Thunderbird dash controls and the tail-light FSM. It synchronises and debounces the left lever, right lever and hazard button, and latches the hazard button into a push-on/push-off level. It drives clean `LEFT`, `RIGHT` and `HAZ` levels straight into the FSM inputs of the same name.

---
 rtl/t_bird_panel_conditioner.sv | 93 +++++++++
 tb/tb_t_bird_panel_conditioner.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/t_bird_panel_conditioner.sv
// Thunderbird dash input conditioner: synchronises and debounces the left
// lever, right lever and hazard button, and turns the hazard button into a
// push-on/push-off request level for the tail-light FSM.
module t_bird_panel_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 10000,
    parameter bit          HAZ_TOGGLE      = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic left_sw,
    input  logic right_sw,
    input  logic haz_sw,
    output logic LEFT,
    output logic RIGHT,
    output logic HAZ,
    output logic haz_press,
    output logic lever_fault
);

    localparam int unsigned CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int unsigned NCH  = 3;
    localparam int unsigned CH_L = 0;
    localparam int unsigned CH_R = 1;
    localparam int unsigned CH_H = 2;

    logic [NCH-1:0] raw;
    logic [NCH-1:0] db;
    logic [NCH-1:0] db_nxt;
    logic           haz_tog;

    assign raw = {haz_sw, right_sw, left_sw};

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic             s1;
        logic             s2;
        logic             db_q;
        logic             db_d;
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] cnt_d;

        // Debounce decision: restart on agreement, commit after a full stable run
        always_comb begin
            db_d  = db_q;
            cnt_d = '0;
            if (s2 == db_q) begin
                cnt_d = '0;
            end else if (cnt == CNT_MAX) begin
                db_d  = s2;
                cnt_d = '0;
            end else begin
                cnt_d = cnt + CNT_W'(1);
            end
        end

        // Synchroniser, debounced level and stability counter
        always_ff @(posedge clk) begin
            if (rst) begin
                s1   <= 1'b0;
                s2   <= 1'b0;
                db_q <= 1'b0;
                cnt  <= '0;
            end else begin
                s1   <= raw[i];
                s2   <= s1;
                db_q <= db_d;
                cnt  <= cnt_d;
            end
        end

        assign db[i]     = db_q;
        assign db_nxt[i] = db_d;
    end

    // Press pulse, lever fault and hazard latch, all aligned to the debounced levels
    always_ff @(posedge clk) begin
        if (rst) begin
            haz_press   <= 1'b0;
            lever_fault <= 1'b0;
            haz_tog     <= 1'b0;
        end else begin
            haz_press   <= db_nxt[CH_H] & ~db[CH_H];
            lever_fault <= db_nxt[CH_L] & db_nxt[CH_R];
            haz_tog     <= haz_tog ^ haz_press;
        end
    end

    assign LEFT  = db[CH_L];
    assign RIGHT = db[CH_R];
    assign HAZ   = HAZ_TOGGLE ? haz_tog : db[CH_H];

endmodule

// File: tb/tb_t_bird_panel_conditioner.sv
// Scoreboard bench for t_bird_panel_conditioner: a toggle-mode and a
// level-mode instance share the same raw inputs; expected output vectors are
// queued as each cycle of stimulus is driven and compared after the edge.
module tb_t_bird_panel_conditioner;

    logic clk;
    logic rst;
    logic left_sw;
    logic right_sw;
    logic haz_sw;

    logic t_left, t_right, t_haz, t_press, t_fault;
    logic l_left, l_right, l_haz, l_press, l_fault;

    logic [9:0] exp_q[$];
    logic [9:0] got;
    logic [9:0] want;
    int checks;
    int errors;

    t_bird_panel_conditioner #(.DEBOUNCE_CYCLES(4), .HAZ_TOGGLE(1'b1)) dut (
        .clk(clk), .rst(rst), .left_sw(left_sw), .right_sw(right_sw), .haz_sw(haz_sw),
        .LEFT(t_left), .RIGHT(t_right), .HAZ(t_haz), .haz_press(t_press), .lever_fault(t_fault)
    );

    t_bird_panel_conditioner #(.DEBOUNCE_CYCLES(4), .HAZ_TOGGLE(1'b0)) dut_lvl (
        .clk(clk), .rst(rst), .left_sw(left_sw), .right_sw(right_sw), .haz_sw(haz_sw),
        .LEFT(l_left), .RIGHT(l_right), .HAZ(l_haz), .haz_press(l_press), .lever_fault(l_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Debounced level after edge e for a raw level high before edges a..b-1 (D=4)
    function automatic logic deb(input int e, input int a, input int b);
        return (e >= a + 5) && (e < b + 5);
    endfunction

    // Expected vector for both instances; only HAZ differs between them
    function automatic logic [9:0] mk(input logic l, input logic r, input logic ht,
                                      input logic p, input logic f, input logic hl);
        return {l, r, ht, p, f, l, r, hl, p, f};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_reset();
        for (int e = 0; e < 4; e++) begin
            @(negedge clk);
            rst = 1'b1; left_sw = 1'b1; right_sw = 1'b1; haz_sw = 1'b1;
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_hold e=%0d got=%b want=%b", e, got, want);
            end
        end
        for (int e = 0; e < 3; e++) begin
            @(negedge clk);
            rst = 1'b0; left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
            exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_release e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_clean_latency();
        do_reset();
        for (int e = 0; e < 23; e++) begin
            @(negedge clk);
            rst = 1'b0; left_sw = (e < 10); right_sw = 1'b0; haz_sw = 1'b0;
            exp_q.push_back(mk(deb(e, 0, 10), 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL clean_latency e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int e = 0; e < 30; e++) begin
            @(negedge clk);
            rst = 1'b0; left_sw = 1'b0; haz_sw = 1'b0;
            right_sw = (e >= 18) ? 1'b1 : (((e / 2) % 2) == 1);
            exp_q.push_back(mk(0, (e >= 23), 0, 0, 0, 0));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL bounce e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_haz_toggle();
        logic dbh;
        do_reset();
        for (int e = 0; e < 35; e++) begin
            @(negedge clk);
            rst = 1'b0; left_sw = 1'b0; right_sw = 1'b0;
            haz_sw = (e < 10) || (e >= 20);
            dbh = deb(e, 0, 10) || deb(e, 20, 1000);
            exp_q.push_back(mk(0, 0, (e >= 6 && e < 26), (e == 5 || e == 25), 0, dbh));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL haz_toggle e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_level_fault();
        logic l, r;
        do_reset();
        for (int e = 0; e < 26; e++) begin
            @(negedge clk);
            rst = 1'b0; haz_sw = (e < 12); left_sw = (e >= 2); right_sw = (e >= 4);
            l = deb(e, 2, 1000);
            r = deb(e, 4, 1000);
            exp_q.push_back(mk(l, r, (e >= 6), (e == 5), l & r, deb(e, 0, 12)));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL level_fault e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 0; e < 31; e++) begin
            @(negedge clk);
            rst = (e == 20); haz_sw = (e < 10); left_sw = (e >= 16); right_sw = 1'b0;
            if (e < 20)
                exp_q.push_back(mk(0, 0, (e >= 6), (e == 5), 0, deb(e, 0, 10)));
            else if (e == 20)
                exp_q.push_back(mk(0, 0, 0, 0, 0, 0));
            else
                exp_q.push_back(mk((e >= 26), 0, 0, 0, 0, 0));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_mid e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    task automatic test_min_glitch();
        do_reset();
        for (int e = 0; e < 33; e++) begin
            @(negedge clk);
            rst = 1'b0; left_sw = 1'b0; right_sw = 1'b0;
            haz_sw = (e < 3) || (e >= 15 && e < 20);
            exp_q.push_back(mk(0, 0, (e >= 21), (e == 20), 0, deb(e, 15, 20)));
            @(posedge clk); #1;
            got  = {t_left, t_right, t_haz, t_press, t_fault, l_left, l_right, l_haz, l_press, l_fault};
            want = exp_q.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL min_glitch e=%0d got=%b want=%b", e, got, want);
            end
        end
    endtask

    // Hard stop in case stimulus ever stalls
    initial begin
        #1000000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; left_sw = 1'b0; right_sw = 1'b0; haz_sw = 1'b0;
        test_reset();
        test_clean_latency();
        test_bounce();
        test_haz_toggle();
        test_level_fault();
        test_reset_mid();
        test_min_glitch();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
